// File: rtl/vector_exec_issue_ctrl_if.sv
// Bundle of signals between the vector issue sequencer and its neighbours:
// decoded-op input, execution unit port and writeback output.
`ifndef MAX_VLEN
`define MAX_VLEN 64
`endif

interface vector_exec_issue_ctrl_if #(
    parameter int VLEN  = `MAX_VLEN,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [VLEN-1:0]  in_data_1;
    logic [VLEN-1:0]  in_data_2;
    logic [2:0]       in_op;
    logic [6:0]       in_sew;
    logic             in_ctrl;
    logic             in_signed;
    logic             in_mul_high;
    logic             in_rsub;
    logic [4:0]       in_bitwise_op;
    logic [1:0]       in_op_type;
    logic [2:0]       in_cmp_op;
    logic [TAG_W-1:0] in_tag;

    logic [VLEN-1:0]  eu_data_1;
    logic [VLEN-1:0]  eu_data_2;
    logic [2:0]       eu_execution_op;
    logic [6:0]       eu_sew;
    logic             eu_ctrl;
    logic             eu_signed;
    logic             eu_mul_high;
    logic             eu_mul_low;
    logic             eu_rsub;
    logic [4:0]       eu_bitwise_op;
    logic [1:0]       eu_op_type;
    logic [2:0]       eu_cmp_op;
    logic [TAG_W-1:0] eu_tag;
    logic [VLEN-1:0]  eu_result;
    logic             eu_count_0;

    logic             out_valid;
    logic             out_ready;
    logic [VLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        input  in_valid, in_data_1, in_data_2, in_op, in_sew, in_ctrl, in_signed,
               in_mul_high, in_rsub, in_bitwise_op, in_op_type, in_cmp_op, in_tag,
               eu_result, eu_count_0, out_ready,
        output in_ready,
               eu_data_1, eu_data_2, eu_execution_op, eu_sew, eu_ctrl, eu_signed,
               eu_mul_high, eu_mul_low, eu_rsub, eu_bitwise_op, eu_op_type,
               eu_cmp_op, eu_tag,
               out_valid, out_result, out_tag, out_err
    );

    modport slave (
        output in_valid, in_data_1, in_data_2, in_op, in_sew, in_ctrl, in_signed,
               in_mul_high, in_rsub, in_bitwise_op, in_op_type, in_cmp_op, in_tag,
               eu_result, eu_count_0, out_ready,
        input  in_ready,
               eu_data_1, eu_data_2, eu_execution_op, eu_sew, eu_ctrl, eu_signed,
               eu_mul_high, eu_mul_low, eu_rsub, eu_bitwise_op, eu_op_type,
               eu_cmp_op, eu_tag,
               out_valid, out_result, out_tag, out_err
    );
endinterface

// File: rtl/vector_exec_issue_ctrl.sv
// Issue sequencer for the vector execution unit: holds one op on the EU ports,
// waits for completion and returns the result. Define VEC_ISSUE_PERF_EN for perf counters.
`ifndef MAX_VLEN
`define MAX_VLEN 64
`endif

module vector_exec_issue_ctrl #(
    parameter int VLEN        = `MAX_VLEN,
    parameter int TAG_W       = 5,
    parameter int MUL_MAX_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
`ifdef VEC_ISSUE_PERF_EN
    output logic [31:0] perf_issued,
    output logic [31:0] perf_mul_stall,
`endif
    vector_exec_issue_ctrl_if.master bus
);

    localparam logic [2:0]       OP_MUL  = 3'b011;
    localparam logic [2:0]       OP_NOP  = 3'b111;
    localparam int               CNT_W   = $clog2(MUL_MAX_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MUL_MAX_CYC);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL_WAIT,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] mul_cnt;
    logic             bad_q;

    logic [VLEN-1:0]  eu_data_1_q;
    logic [VLEN-1:0]  eu_data_2_q;
    logic [2:0]       eu_op_q;
    logic [6:0]       eu_sew_q;
    logic             eu_ctrl_q;
    logic             eu_signed_q;
    logic             eu_mul_high_q;
    logic             eu_mul_low_q;
    logic             eu_rsub_q;
    logic [4:0]       eu_bitwise_op_q;
    logic [1:0]       eu_op_type_q;
    logic [2:0]       eu_cmp_op_q;
    logic [TAG_W-1:0] eu_tag_q;

    logic             out_valid_q;
    logic [VLEN-1:0]  out_result_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_err_q;

    logic sew_ok;
    logic op_bad;
    logic in_ready_w;
    logic accept;

    assign sew_ok     = (bus.in_sew == 7'b0001000) || (bus.in_sew == 7'b0010000) ||
                        (bus.in_sew == 7'b0100000);
    assign op_bad     = (bus.in_op == 3'b010) || (bus.in_op == OP_NOP) || !sew_ok;
    assign in_ready_w = (state == IDLE) || ((state == RESP) && bus.out_ready);
    assign accept     = bus.in_valid && in_ready_w;

    // Completion paths return the EU to its gated no-op; an accept in the same
    // cycle (RESP release) overrides that with the next op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            mul_cnt         <= '0;
            bad_q           <= 1'b0;
            eu_data_1_q     <= '0;
            eu_data_2_q     <= '0;
            eu_op_q         <= OP_NOP;
            eu_sew_q        <= '0;
            eu_ctrl_q       <= 1'b0;
            eu_signed_q     <= 1'b0;
            eu_mul_high_q   <= 1'b0;
            eu_mul_low_q    <= 1'b0;
            eu_rsub_q       <= 1'b0;
            eu_bitwise_op_q <= '0;
            eu_op_type_q    <= '0;
            eu_cmp_op_q     <= '0;
            eu_tag_q        <= '0;
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_tag_q       <= '0;
            out_err_q       <= 1'b0;
        end else begin
            case (state)
                EXEC: begin
                    out_result_q <= bad_q ? '0 : bus.eu_result;
                    out_err_q    <= bad_q;
                    out_tag_q    <= eu_tag_q;
                    out_valid_q  <= 1'b1;
                    eu_op_q      <= OP_NOP;
                    eu_data_1_q  <= '0;
                    eu_data_2_q  <= '0;
                    state        <= RESP;
                end
                MUL_WAIT: begin
                    // A product arriving on the watchdog's last cycle still counts.
                    if (bus.eu_count_0 || (mul_cnt == CNT_MAX)) begin
                        out_result_q <= bus.eu_count_0 ? bus.eu_result : '0;
                        out_err_q    <= !bus.eu_count_0;
                        out_tag_q    <= eu_tag_q;
                        out_valid_q  <= 1'b1;
                        eu_op_q      <= OP_NOP;
                        eu_data_1_q  <= '0;
                        eu_data_2_q  <= '0;
                        state        <= RESP;
                    end else begin
                        mul_cnt <= mul_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                end
            endcase

            if (accept) begin
                bad_q           <= op_bad;
                mul_cnt         <= CNT_W'(1);
                eu_op_q         <= op_bad ? OP_NOP : bus.in_op;
                eu_data_1_q     <= op_bad ? '0 : bus.in_data_1;
                eu_data_2_q     <= op_bad ? '0 : bus.in_data_2;
                eu_sew_q        <= bus.in_sew;
                eu_ctrl_q       <= bus.in_ctrl;
                eu_signed_q     <= bus.in_signed;
                eu_mul_high_q   <= bus.in_mul_high;
                eu_mul_low_q    <= !bus.in_mul_high;
                eu_rsub_q       <= bus.in_rsub;
                eu_bitwise_op_q <= bus.in_bitwise_op;
                eu_op_type_q    <= bus.in_op_type;
                eu_cmp_op_q     <= bus.in_cmp_op;
                eu_tag_q        <= bus.in_tag;
                state           <= (!op_bad && (bus.in_op == OP_MUL)) ? MUL_WAIT : EXEC;
            end
        end
    end

`ifdef VEC_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued    <= '0;
            perf_mul_stall <= '0;
        end else begin
            if (accept) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (state == MUL_WAIT) begin
                perf_mul_stall <= perf_mul_stall + 32'd1;
            end
        end
    end
`endif

    assign bus.in_ready        = in_ready_w;
    assign bus.eu_data_1       = eu_data_1_q;
    assign bus.eu_data_2       = eu_data_2_q;
    assign bus.eu_execution_op = eu_op_q;
    assign bus.eu_sew          = eu_sew_q;
    assign bus.eu_ctrl         = eu_ctrl_q;
    assign bus.eu_signed       = eu_signed_q;
    assign bus.eu_mul_high     = eu_mul_high_q;
    assign bus.eu_mul_low      = eu_mul_low_q;
    assign bus.eu_rsub         = eu_rsub_q;
    assign bus.eu_bitwise_op   = eu_bitwise_op_q;
    assign bus.eu_op_type      = eu_op_type_q;
    assign bus.eu_cmp_op       = eu_cmp_op_q;
    assign bus.eu_tag          = eu_tag_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_result      = out_result_q;
    assign bus.out_tag         = out_tag_q;
    assign bus.out_err         = out_err_q;

endmodule
